// File: rtl/keypad_pkg.sv
// Shared types for the keypad key queue: key code width, the debounced
// {pressed, key} sample pair, and the debounce state encoding.
// Imported by keypad_event_fifo and keypad_key_queue.
package keypad_pkg;

  localparam int KEY_W = 4;

  typedef logic [KEY_W-1:0] key_t;

  // One sampled observation of the encoder outputs
  typedef struct packed {
    logic pressed;
    key_t key;
  } samp_t;

  typedef enum logic [1:0] {
    REL      = 2'd0,
    PRESS_DB = 2'd1,
    HELD     = 2'd2,
    REL_DB   = 2'd3
  } deb_state_t;

endpackage

// File: rtl/keypad_event_fifo.sv
// Event FIFO: DEPTH x key_t, head entry and valid held in registers (0 when empty).
// Latency: a push into an empty FIFO is visible one cycle later; no bypass.
// Backpressure: pop only when valid; a push while full is accepted only if a pop frees a slot.
module keypad_event_fifo
  import keypad_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_push,
  input  key_t                   i_push_dat,
  input  logic                   i_pop,
  output logic                   o_full,
  output logic                   o_vld,
  output key_t                   o_dat,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  key_t          r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          r_vld;
  key_t          r_dat;

  logic          w_pop;
  logic          w_push;
  logic [AW-1:0] w_rd_next;
  logic [AW:0]   w_cnt_after_pop;
  logic [AW:0]   w_cnt_next;
  key_t          w_dat_next;

  assign o_full          = (r_count == FULL_CNT);
  assign w_pop           = i_pop & r_vld;
  assign w_push          = i_push & (~o_full | w_pop);
  assign w_rd_next       = r_rd_ptr + AW'(w_pop);
  assign w_cnt_after_pop = r_count - (AW+1)'(w_pop);
  assign w_cnt_next      = w_cnt_after_pop + (AW+1)'(w_push);

  // Next head: oldest surviving entry, else the entry being pushed, else 0
  always_comb begin
    w_dat_next = '0;
    if (w_cnt_after_pop != '0) begin
      w_dat_next = r_mem[w_rd_next];
    end else if (w_push) begin
      w_dat_next = i_push_dat;
    end
  end

  // Storage array; pointers wrap naturally because DEPTH is a power of 2
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_push_dat;
    end
  end

  // Pointers, occupancy and registered head outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_vld    <= 1'b0;
      r_dat    <= '0;
    end else begin
      r_wr_ptr <= r_wr_ptr + AW'(w_push);
      r_rd_ptr <= w_rd_next;
      r_count  <= w_cnt_next;
      r_vld    <= (w_cnt_next != '0);
      r_dat    <= w_dat_next;
    end
  end

  assign o_vld   = r_vld;
  assign o_dat   = r_dat;
  assign o_count = r_count;

endmodule

// File: rtl/keypad_key_queue.sv
// Debounces {key_pressed, key_in}, emits one event per press into a small FIFO; sticky overflow.
// Latency: input change to key_valid is DEBOUNCE_CYCLES+2 cycles (push on edge DEBOUNCE_CYCLES+1).
// Backpressure: valid/ready pop; events arriving while full with no pop are dropped and flag overflow.
// Optional auto-repeat of a held key is enabled by defining KEYPAD_AUTOREPEAT_EN.
module keypad_key_queue
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int DEPTH           = 4,
  parameter int REPEAT_DELAY    = 4096,
  parameter int REPEAT_PERIOD   = 1024
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [KEY_W-1:0]       key_in,
  input  logic                   key_pressed,
  output logic [KEY_W-1:0]       key_code,
  output logic                   key_valid,
  input  logic                   key_ready,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   overflow,
  input  logic                   clear_ovf
);

  // Elaboration-time guard against unusable configurations
  if (DEBOUNCE_CYCLES < 2 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 ||
      REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_cfg
    $error("keypad_key_queue: invalid parameter set");
  end

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  samp_t      r_sample;
  samp_t      r_cand;
  samp_t      r_stable;
  logic [CW-1:0] r_cnt;
  deb_state_t r_state;
  logic       r_ovf;

  logic w_same;
  logic w_done;
  logic w_deb_push;
  logic w_push;
  logic w_pop;
  logic w_full;

  assign w_same     = (r_sample == r_cand);
  assign w_done     = w_same && (r_cnt == CNT_MAX);
  assign w_deb_push = (r_state == PRESS_DB) && r_sample.pressed && w_done;
  assign w_pop      = key_valid & key_ready;

  // Register the raw encoder outputs once per cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sample <= '0;
    end else begin
      r_sample <= '{pressed: key_pressed, key: key_in};
    end
  end

  // Debounce FSM: candidate/count tracking plus stable-state transitions
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= REL;
      r_cand   <= '0;
      r_stable <= '0;
      r_cnt    <= '0;
    end else begin
      if (!w_same) begin
        r_cand <= r_sample;
        r_cnt  <= '0;
      end else if (r_cnt != CNT_MAX) begin
        r_cnt <= r_cnt + CW'(1);
      end
      case (r_state)
        REL: begin
          if (r_sample.pressed) r_state <= PRESS_DB;
        end
        PRESS_DB: begin
          if (!r_sample.pressed) begin
            r_state <= REL;
          end else if (w_done) begin
            r_state  <= HELD;
            r_stable <= r_sample;
          end
        end
        HELD: begin
          if (!r_sample.pressed) begin
            r_state <= REL_DB;
          end else if (r_sample.key != r_stable.key) begin
            r_state <= PRESS_DB;
          end
        end
        REL_DB: begin
          // A bounce back to the same key resumes HELD silently
          if (r_sample.pressed) begin
            r_state <= (r_sample == r_stable) ? HELD : PRESS_DB;
          end else if (w_done) begin
            r_state  <= REL;
            r_stable <= r_sample;
          end
        end
        default: r_state <= REL;
      endcase
    end
  end

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW      = $clog2(REP_MAX + 1);

  logic [RW-1:0] r_rep_cnt;
  logic          r_rep_first;
  logic          w_hold_stay;
  logic [RW-1:0] w_rep_lim;
  logic          w_rep_push;

  assign w_hold_stay = (r_state == HELD) && (r_sample == r_stable);
  assign w_rep_lim   = r_rep_first ? RW'(REPEAT_DELAY - 1) : RW'(REPEAT_PERIOD - 1);
  assign w_rep_push  = w_hold_stay && (r_rep_cnt == w_rep_lim);

  // Repeat timer: first interval REPEAT_DELAY, then REPEAT_PERIOD; restarts when HELD is left
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rep_cnt   <= '0;
      r_rep_first <= 1'b1;
    end else if (!w_hold_stay) begin
      r_rep_cnt   <= '0;
      r_rep_first <= 1'b1;
    end else if (w_rep_push) begin
      r_rep_cnt   <= '0;
      r_rep_first <= 1'b0;
    end else begin
      r_rep_cnt <= r_rep_cnt + RW'(1);
    end
  end

  assign w_push = w_deb_push | w_rep_push;
`else
  assign w_push = w_deb_push;
`endif

  keypad_event_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_push    (w_push),
    .i_push_dat(r_sample.key),
    .i_pop     (w_pop),
    .o_full    (w_full),
    .o_vld     (key_valid),
    .o_dat     (key_code),
    .o_count   (fifo_count)
  );

  // Sticky overflow: a dropped event wins over a same-cycle clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (w_push && w_full && !w_pop) begin
      r_ovf <= 1'b1;
    end else if (clear_ovf) begin
      r_ovf <= 1'b0;
    end
  end

  assign overflow = r_ovf;

endmodule

// File: tb/tb_keypad_key_queue.sv
// Bench for keypad_key_queue (DEBOUNCE_CYCLES=4, DEPTH=4, REPEAT_DELAY=20, REPEAT_PERIOD=8).
// The reference model works from sample history: a press is accepted after D+1 identical samples.
// Directed scenarios followed by randomized stimulus; macro KEYPAD_AUTOREPEAT_EN selects repeat checks.
module tb_keypad_key_queue;

  localparam int D     = 4;
  localparam int DEPTH = 4;
  localparam int RD    = 20;
  localparam int RP    = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [3:0]    key_in = 4'h0;
  logic          key_pressed = 1'b0;
  logic          key_ready = 1'b0;
  logic          clear_ovf = 1'b0;
  logic [3:0]    key_code;
  logic          key_valid;
  logic [CW-1:0] fifo_count;
  logic          overflow;
  logic [8:0]    dut_vec;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  keypad_key_queue #(
    .DEBOUNCE_CYCLES(D),
    .DEPTH          (DEPTH),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_in     (key_in),
    .key_pressed(key_pressed),
    .key_code   (key_code),
    .key_valid  (key_valid),
    .key_ready  (key_ready),
    .fifo_count (fifo_count),
    .overflow   (overflow),
    .clear_ovf  (clear_ovf)
  );

  assign dut_vec = {key_valid, key_code, fifo_count, overflow};

  // ---------------- reference model ----------------
  logic [3:0] q[$];
  logic       m_sp;     // last registered sample: pressed
  logic [3:0] m_sk;     // last registered sample: key
  int         m_run;    // consecutive identical samples ending at the last one
  logic       m_hv;     // a key is currently accepted as held
  logic [3:0] m_hk;
  logic       m_hp;     // held and steady (repeat timer running)
  int         m_rep;
  int         m_next;
  logic       m_ovf;

  function automatic void model_reset();
    q.delete();
    m_sp = 1'b0; m_sk = 4'h0; m_run = 2;
    m_hv = 1'b0; m_hk = 4'h0; m_hp = 1'b0;
    m_rep = 0; m_next = RD; m_ovf = 1'b0;
  endfunction

  // One clock edge: p/k are the inputs being registered now, m_sp/m_sk the sample being judged
  function automatic void model_edge(input logic p, input logic [3:0] k, input logic rdy, input logic clr);
    logic ev;
    logic popped;
    logic full_before;
    ev = 1'b0;
    if (m_sp) begin
      if (m_hv && m_sk == m_hk) begin
`ifdef KEYPAD_AUTOREPEAT_EN
        if (m_hp) begin
          m_rep++;
          if (m_rep == m_next) begin
            ev = 1'b1; m_rep = 0; m_next = RP;
          end
        end else begin
          m_hp = 1'b1; m_rep = 0; m_next = RD;
        end
`endif
      end else begin
        m_hv = 1'b0; m_hp = 1'b0;
        if (m_run == D + 1) begin
          ev = 1'b1; m_hv = 1'b1; m_hk = m_sk;
          m_hp = 1'b1; m_rep = 0; m_next = RD;
        end
      end
    end else begin
      m_hp = 1'b0;
      if (m_run == D + 1) m_hv = 1'b0;
    end
    full_before = (q.size() == DEPTH);
    popped = (q.size() > 0) && rdy;
    if (popped) void'(q.pop_front());
    if (ev && full_before && !popped) m_ovf = 1'b1;
    else begin
      if (ev) q.push_back(m_sk);
      if (clr) m_ovf = 1'b0;
    end
    if (p == m_sp && k == m_sk) m_run++;
    else m_run = 1;
    m_sp = p; m_sk = k;
  endfunction

  function automatic logic [8:0] exp_vec();
    logic [3:0] h;
    h = (q.size() > 0) ? q[0] : 4'h0;
    return {q.size() > 0, h, CW'(q.size()), m_ovf};
  endfunction

  // Drive inputs, advance one edge, update model, settle
  task automatic tick(input logic p, input logic [3:0] k, input logic rdy, input logic clr);
    key_pressed = p; key_in = k; key_ready = rdy; clear_ovf = clr;
    @(posedge clk);
    model_edge(p, k, rdy, clr);
    #1;
  endtask

  task automatic press(input logic [3:0] k, input int hold, input int rel, input logic rdy);
    for (int i = 0; i < hold; i++) tick(1'b1, k, rdy, 1'b0);
    for (int i = 0; i < rel; i++) tick(1'b0, k, rdy, 1'b0);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0; key_pressed = 1'b0; key_in = 4'h0; key_ready = 1'b0; clear_ovf = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (dut_vec !== 9'h000) begin
      n_err++; $display("FAIL reset_state: got %h, want 000", dut_vec);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 4'h0, 1'b1, 1'b0);
      n_checks++;
      if (dut_vec !== exp_vec()) begin
        n_err++; $display("FAIL reset_idle tick %0d: got %h, want %h", i, dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_clean_press();
    int first = -1;
    int nval = 0;
    logic [3:0] code = 4'h0;
    for (int i = 0; i < 20; i++) begin
      tick(i < 10, 4'h7, 1'b1, 1'b0);
      n_checks++;
      if (dut_vec !== exp_vec()) begin
        n_err++; $display("FAIL clean_model tick %0d: got %h, want %h", i, dut_vec, exp_vec());
      end
      if (key_valid === 1'b1) begin
        nval++;
        if (first < 0) begin first = i; code = key_code; end
      end
    end
    n_checks++;
    if (first != D + 1) begin n_err++; $display("FAIL clean_latency: first valid after edge %0d, want %0d", first, D + 1); end
    n_checks++;
    if (nval != 1) begin n_err++; $display("FAIL clean_count: %0d valid cycles, want 1", nval); end
    n_checks++;
    if (code !== 4'h7) begin n_err++; $display("FAIL clean_code: got %h, want 7", code); end
  endtask

  task automatic test_bounce();
    int first = -1;
    int nval = 0;
    for (int i = 0; i < 26; i++) begin
      tick((i < 4) ? (i % 2 == 0) : (i < 16), 4'h3, 1'b1, 1'b0);
      n_checks++;
      if (dut_vec !== exp_vec()) begin
        n_err++; $display("FAIL bounce_model tick %0d: got %h, want %h", i, dut_vec, exp_vec());
      end
      if (key_valid === 1'b1) begin
        nval++;
        if (first < 0) first = i;
      end
    end
    n_checks++;
    if (first != 4 + D + 1) begin n_err++; $display("FAIL bounce_latency: first valid after edge %0d, want %0d", first, 4 + D + 1); end
    n_checks++;
    if (nval != 1) begin n_err++; $display("FAIL bounce_count: %0d valid cycles, want 1", nval); end
  endtask

  task automatic test_overflow();
    logic [3:0] got[$];
    for (int k = 1; k <= 5; k++) press(4'(k), 6, 8, 1'b0);
    n_checks++;
    if (fifo_count !== 3'd4) begin n_err++; $display("FAIL ovf_count: got %0d, want 4", fifo_count); end
    n_checks++;
    if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_flag: got %b, want 1", overflow); end
    n_checks++;
    if (dut_vec !== exp_vec()) begin n_err++; $display("FAIL ovf_model: got %h, want %h", dut_vec, exp_vec()); end
    for (int i = 0; i < 6; i++) begin
      if (key_valid === 1'b1) got.push_back(key_code);
      tick(1'b0, 4'h5, 1'b1, 1'b0);
    end
    n_checks++;
    if (got.size() != 4) begin n_err++; $display("FAIL ovf_drain_len: got %0d entries, want 4", got.size()); end
    for (int j = 0; j < got.size() && j < 4; j++) begin
      n_checks++;
      if (got[j] !== 4'(j + 1)) begin n_err++; $display("FAIL ovf_drain_order[%0d]: got %h, want %h", j, got[j], 4'(j + 1)); end
    end
    n_checks++;
    if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_sticky: got %b, want 1", overflow); end
    tick(1'b0, 4'h5, 1'b1, 1'b1);
    n_checks++;
    if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_clear: got %b, want 0", overflow); end
  endtask

  task automatic test_full_push_pop();
    logic [3:0] got[$];
    logic [3:0] want[4];
    want[0] = 4'h2; want[1] = 4'h3; want[2] = 4'h4; want[3] = 4'h9;
    for (int k = 1; k <= 4; k++) press(4'(k), 6, 8, 1'b0);
    n_checks++;
    if (fifo_count !== 3'd4) begin n_err++; $display("FAIL full_fill: count %0d, want 4", fifo_count); end
    for (int i = 0; i < 10; i++) tick(1'b1, 4'h9, i == D + 1, 1'b0);
    n_checks++;
    if (overflow !== 1'b0) begin n_err++; $display("FAIL full_pp_ovf: got %b, want 0", overflow); end
    n_checks++;
    if (fifo_count !== 3'd4) begin n_err++; $display("FAIL full_pp_count: got %0d, want 4", fifo_count); end
    for (int i = 0; i < 8; i++) tick(1'b0, 4'h9, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      if (key_valid === 1'b1) got.push_back(key_code);
      tick(1'b0, 4'h9, 1'b1, 1'b0);
    end
    n_checks++;
    if (got.size() != 4) begin n_err++; $display("FAIL full_pp_len: got %0d entries, want 4", got.size()); end
    for (int j = 0; j < got.size() && j < 4; j++) begin
      n_checks++;
      if (got[j] !== want[j]) begin n_err++; $display("FAIL full_pp_order[%0d]: got %h, want %h", j, got[j], want[j]); end
    end
  endtask

  task automatic test_reset_mid();
    int first = -1;
    press(4'h6, 6, 8, 1'b0);
    press(4'h7, 6, 8, 1'b0);
    tick(1'b1, 4'h5, 1'b0, 1'b0);
    tick(1'b1, 4'h5, 1'b0, 1'b0);
    n_checks++;
    if (fifo_count !== 3'd2) begin n_err++; $display("FAIL rstmid_pre: count %0d, want 2", fifo_count); end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (dut_vec !== 9'h000) begin n_err++; $display("FAIL rstmid_async: got %h, want 000", dut_vec); end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick(1'b1, 4'h5, 1'b0, 1'b0);
      n_checks++;
      if (dut_vec !== exp_vec()) begin
        n_err++; $display("FAIL rstmid_model tick %0d: got %h, want %h", i, dut_vec, exp_vec());
      end
      if (key_valid === 1'b1 && first < 0) first = i;
    end
    n_checks++;
    if (first != D + 1) begin n_err++; $display("FAIL rstmid_fresh: first valid after edge %0d, want %0d", first, D + 1); end
    press(4'h5, 0, 10, 1'b1);
  endtask

  task automatic test_autorepeat();
    int nval = 0;
`ifdef KEYPAD_AUTOREPEAT_EN
    int want = 5;
`else
    int want = 1;
`endif
    for (int i = 0; i < 60; i++) begin
      tick(i < 50, 4'hA, 1'b1, 1'b0);
      n_checks++;
      if (dut_vec !== exp_vec()) begin
        n_err++; $display("FAIL repeat_model tick %0d: got %h, want %h", i, dut_vec, exp_vec());
      end
      if (key_valid === 1'b1) nval++;
    end
    n_checks++;
    if (nval != want) begin n_err++; $display("FAIL repeat_count: %0d events, want %0d", nval, want); end
  endtask

  task automatic test_random();
    logic p;
    logic [3:0] k;
    int hold;
    for (int seg = 0; seg < 200; seg++) begin
      p = 1'($urandom_range(0, 1));
      k = 4'($urandom_range(0, 3));
      hold = (seg % 3 == 0) ? $urandom_range(6, 30) : $urandom_range(1, 8);
      for (int j = 0; j < hold; j++) begin
        tick(p, k, $urandom_range(0, 9) < 4, $urandom_range(0, 19) == 0);
        n_checks++;
        if (dut_vec !== exp_vec()) begin
          n_err++; $display("FAIL random seg %0d: got %h, want %h", seg, dut_vec, exp_vec());
        end
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    model_reset();
    test_reset();
    test_clean_press();
    test_bounce();
    test_overflow();
    test_full_push_pop();
    test_reset_mid();
    test_autorepeat();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/keypad_key_queue.md
Name: keypad_key_queue

Overview:
- Sits directly downstream of keypad_encoder. Consumes its 4-bit key code plus a key-pressed flag.
- Debounces the {pressed, key} pair and emits exactly one event per debounced press.
- Buffers events in a small FIFO presented on a valid/ready interface to the consuming logic (e.g. PIN/command parser).
- Sticky overflow flag records dropped events.

Parameters:
- DEBOUNCE_CYCLES, 16: consecutive identical samples required before the input is accepted as stable; must be ≥2.
- DEPTH, 4: FIFO entries; must be a power of 2, ≥2.
- REPEAT_DELAY, 4096: cycles held before the first auto-repeat; used only with KEYPAD_AUTOREPEAT_EN.
- REPEAT_PERIOD, 1024: cycles between subsequent repeats; used only with KEYPAD_AUTOREPEAT_EN.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- key_in  in  4  key code from keypad_encoder
- key_pressed  in  1  1 = a key is currently down
- key_code  out  4  FIFO head entry; 0 when the FIFO is empty
- key_valid  out  1  FIFO non-empty
- key_ready  in  1  consumer accepts the head entry when key_valid && key_ready
- fifo_count  out  $clog2(DEPTH)+1  number of occupied entries
- overflow  out  1  sticky; set when an event is dropped
- clear_ovf  in  1  synchronous clear of overflow

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset state: all outputs 0; sample/candidate/stable registers = {released, 4'h0}; counters 0; FIFO empty.
- Reset asserted mid-operation: queued events are discarded and the debounce state restarts.
- Input sampling: {key_pressed, key_in} is registered once per cycle into a sample register.
- Debounce FSM states:
  - REL: stable released.
  - PRESS_DB: candidate pressed, counting.
  - HELD: stable pressed.
  - REL_DB: candidate released, counting.
- Counting rule: whenever the sample differs from the candidate, candidate ← sample and count ← 0. Otherwise count increments, saturating at DEBOUNCE_CYCLES-1.
- Transitions:
  - REL→PRESS_DB on a pressed sample.
  - PRESS_DB→HELD when count reaches DEBOUNCE_CYCLES-1 with candidate pressed.
  - PRESS_DB→REL if a released sample arrives first.
  - HELD→REL_DB on a released sample.
  - REL_DB→REL on count completion.
  - REL_DB→HELD if a pressed sample with the same key returns.
  - HELD with a different pressed key code re-enters PRESS_DB for the new code.
- Events:
  - Entering HELD, including HELD via the different-key path, generates one push of the candidate key code.
  - REL_DB→HELD with the same key pushes nothing.
  - Release never pushes.
- Latency: with inputs changed before edge 0 and held constant, the push occurs at edge DEBOUNCE_CYCLES+1, and key_valid is high after that edge, i.e. DEBOUNCE_CYCLES+2 cycles from the input change.
- FIFO behaviour:
  - Pop on key_valid && key_ready.
  - key_code/key_valid are registered head outputs with no combinational path from key_ready.
  - Push when full: new event dropped, overflow ← 1, contents unchanged.
  - Push and pop in the same cycle while full: both succeed, no overflow, count unchanged.
  - Push while empty: key_valid rises the next cycle. There is no same-cycle bypass.
  - Pointers wrap modulo DEPTH.
- overflow: set has priority over clear_ovf in the same cycle.

Optional Feature:
- Macro: KEYPAD_AUTOREPEAT_EN.
- Defined:
  - While in HELD, a repeat counter runs.
  - After REPEAT_DELAY cycles in HELD, the held code is pushed again, then every REPEAT_PERIOD cycles.
  - The counter resets on leaving HELD or on a key change.
  - Repeats obey the normal overflow rules.
- Undefined: no repeat counter is synthesized; exactly one event per press; REPEAT_* parameters are ignored.

Decomposition:
- Package keypad_pkg:
  - KEY_W = 4.
  - typedef key_t (logic [KEY_W-1:0]).
  - typedef deb_state_t enum {REL, PRESS_DB, HELD, REL_DB}.
- Sub-module keypad_event_fifo: generic DEPTH × key_t FIFO with push/full/pop/valid/count. The top holds sampling, debounce FSM, repeat logic and overflow.

Test Plan (DEBOUNCE_CYCLES=4, DEPTH=4, key_ready=1 unless stated):
- Clean press: key_in=4'h7, pressed=1 held 10 cycles from edge 0 → key_valid=1 with key_code=7 for exactly one cycle, first seen after edge 5; nothing on release.
- Bounce: pressed toggles 1,0,1,0 every cycle, then held 1 with key 4'h3 → single event key_code=3, issued 6 cycles after the last toggle; no spurious events.
- Overflow: key_ready=0; press/release keys 1,2,3,4,5 → fifo_count=4, overflow=1. Drain yields 1,2,3,4 in order. clear_ovf → overflow=0.
- Full push+pop: FIFO full, key_ready=1 coincident with a new push of key 9 → no overflow, count stays 4, 9 appears last.
- Reset mid-operation: rst_n low while 2 entries queued and PRESS_DB active → all outputs 0 immediately (asynchronous); after release no event until a fresh debounced press.
- Autorepeat (macro defined, REPEAT_DELAY=20, REPEAT_PERIOD=8): hold key 4'hA for 50 cycles → events at initial press +20 and +28 (+36, +44 also), exactly one per interval; macro undefined → single event.
